// File: rtl/dual_port_ram_sync_if.sv
// Port bundle for dual_port_ram_sync: two independent request/response ports plus status flags.
// The parity error outputs exist only when DPRAM_PARITY_EN is defined.
interface dual_port_ram_sync_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8
);
    logic                 cs_a;
    logic                 wr_a;
    logic [ADDR_SIZE-1:0] addr_a;
    logic [WORD_SIZE-1:0] data_a;
    logic [WORD_SIZE-1:0] out_a;
    logic                 valid_a;
    logic                 cs_b;
    logic                 wr_b;
    logic [ADDR_SIZE-1:0] addr_b;
    logic [WORD_SIZE-1:0] data_b;
    logic [WORD_SIZE-1:0] out_b;
    logic                 valid_b;
    logic                 busy;
    logic                 collision;
    logic                 addr_err;
`ifdef DPRAM_PARITY_EN
    logic                 parity_err_a;
    logic                 parity_err_b;

    modport master (
        output cs_a, wr_a, addr_a, data_a, cs_b, wr_b, addr_b, data_b,
        input  out_a, valid_a, out_b, valid_b, busy, collision, addr_err,
        input  parity_err_a, parity_err_b
    );
    modport slave (
        input  cs_a, wr_a, addr_a, data_a, cs_b, wr_b, addr_b, data_b,
        output out_a, valid_a, out_b, valid_b, busy, collision, addr_err,
        output parity_err_a, parity_err_b
    );
`else
    modport master (
        output cs_a, wr_a, addr_a, data_a, cs_b, wr_b, addr_b, data_b,
        input  out_a, valid_a, out_b, valid_b, busy, collision, addr_err
    );
    modport slave (
        input  cs_a, wr_a, addr_a, data_a, cs_b, wr_b, addr_b, data_b,
        output out_a, valid_a, out_b, valid_b, busy, collision, addr_err
    );
`endif
endinterface

// File: rtl/dual_port_ram_sync.sv
// Synchronous true dual-port RAM with read-first semantics, post-reset hardware clear and
// 1- or 2-cycle read latency. Optional per-word even parity via DPRAM_PARITY_EN.
module dual_port_ram_sync #(
    parameter int ADDR_SIZE    = 10,
    parameter int WORD_SIZE    = 8,
    parameter int MEMORY_SIZE  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    dual_port_ram_sync_if.slave bus
);
`ifdef DPRAM_PARITY_EN
    localparam int MEM_W = WORD_SIZE + 1;
`else
    localparam int MEM_W = WORD_SIZE;
`endif
    localparam logic [ADDR_SIZE:0]   ADDR_LIMIT = (ADDR_SIZE+1)'(MEMORY_SIZE);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(MEMORY_SIZE - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
    logic                 collision_q, collision_d;
    logic                 addr_err_q, addr_err_d;
    logic [1:0]           rd_vld_q, rd_vld_d;

    logic                 accept;
    logic [1:0]           cs, wr, in_range, rd_acc, wr_acc, vld_out;
    logic [ADDR_SIZE-1:0] addr [2];
    logic [WORD_SIZE-1:0] wdata [2];
    logic [MEM_W-1:0]     word_out [2];

    logic                 we_a, we_b;
    logic [ADDR_SIZE-1:0] waddr_a;
    logic [MEM_W-1:0]     wword_a, wword_b;
    logic [MEM_W-1:0]     mem [MEMORY_SIZE];

    function automatic logic [MEM_W-1:0] encode(input logic [WORD_SIZE-1:0] d);
`ifdef DPRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign cs       = {bus.cs_b, bus.cs_a};
    assign wr       = {bus.wr_b, bus.wr_a};
    assign addr[0]  = bus.addr_a;
    assign addr[1]  = bus.addr_b;
    assign wdata[0] = bus.data_a;
    assign wdata[1] = bus.data_b;
    assign accept   = (state_q == READY) && !rst;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        collision_d = 1'b0;
        addr_err_d  = 1'b0;
        rd_vld_d    = rd_acc;
        we_a        = 1'b0;
        waddr_a     = addr[0];
        wword_a     = encode(wdata[0]);
        // Port A wins a same-address write race, so B is simply suppressed.
        we_b        = wr_acc[1] && in_range[1] && !(wr_acc[0] && (addr[0] == addr[1]));
        wword_b     = encode(wdata[1]);
        case (state_q)
            CLEAR: begin
                we_a      = !rst;
                waddr_a   = clr_cnt_q;
                wword_a   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) state_d = READY;
            end
            READY: begin
                we_a        = wr_acc[0] && in_range[0];
                collision_d = wr_acc[0] && wr_acc[1] && (addr[0] == addr[1]);
                addr_err_d  = |((rd_acc | wr_acc) & ~in_range);
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            collision_q <= 1'b0;
            addr_err_q  <= 1'b0;
            rd_vld_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            collision_q <= collision_d;
            addr_err_q  <= addr_err_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_b) mem[addr[1]] <= wword_b;
        if (we_a) mem[waddr_a] <= wword_a;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [MEM_W-1:0] rdata_q;

        assign in_range[gi] = {1'b0, addr[gi]} < ADDR_LIMIT;
        assign rd_acc[gi]   = accept && cs[gi] && !wr[gi];
        assign wr_acc[gi]   = accept && cs[gi] && wr[gi];

        // Nonblocking read alongside the write block gives read-first behaviour.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rd_acc[gi]) begin
                rdata_q <= in_range[gi] ? mem[addr[gi]] : '0;
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [MEM_W-1:0] word2_q, word2_d;
            logic             vld2_q, vld2_d;

            always_comb begin
                vld2_d  = rd_vld_q[gi];
                word2_d = rd_vld_q[gi] ? rdata_q : word2_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word2_q <= '0;
                    vld2_q  <= 1'b0;
                end else begin
                    word2_q <= word2_d;
                    vld2_q  <= vld2_d;
                end
            end

            assign word_out[gi] = word2_q;
            assign vld_out[gi]  = vld2_q;
        end else begin : g_lat1
            assign word_out[gi] = rdata_q;
            assign vld_out[gi]  = rd_vld_q[gi];
        end
    end

    assign bus.out_a     = word_out[0][WORD_SIZE-1:0];
    assign bus.out_b     = word_out[1][WORD_SIZE-1:0];
    assign bus.valid_a   = vld_out[0];
    assign bus.valid_b   = vld_out[1];
    assign bus.busy      = (state_q == CLEAR);
    assign bus.collision = collision_q;
    assign bus.addr_err  = addr_err_q;
`ifdef DPRAM_PARITY_EN
    // A stored word (data plus parity bit) must have even overall parity.
    assign bus.parity_err_a = vld_out[0] && (^word_out[0]);
    assign bus.parity_err_b = vld_out[1] && (^word_out[1]);
`endif
endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Randomized self-checking bench: latency-1 and latency-2 instances (MEMORY_SIZE=1000) share
// one stimulus stream and are compared every cycle against a behavioural memory model.
module tb_dual_port_ram_sync;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MS = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_port_ram_sync_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus1 ();
    dual_port_ram_sync_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus2 ();

    dual_port_ram_sync #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(MS), .READ_LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    dual_port_ram_sync #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(MS), .READ_LATENCY(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus2.cs_a   = bus1.cs_a;
    assign bus2.wr_a   = bus1.wr_a;
    assign bus2.addr_a = bus1.addr_a;
    assign bus2.data_a = bus1.data_a;
    assign bus2.cs_b   = bus1.cs_b;
    assign bus2.wr_b   = bus1.wr_b;
    assign bus2.addr_b = bus1.addr_b;
    assign bus2.data_b = bus1.data_b;

    // Reference model: plain word array, remaining-clear counter, expected outputs per latency.
    logic [DW-1:0] mdl_mem [MS];
    int            rem;
    int            flip_addr;
    logic [DW-1:0] e1_out [2], e2_out [2];
    logic          e1_vld [2], e2_vld [2], e1_perr [2], e2_perr [2];
    logic          e_coll, e_err;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("busy_l1",   bus1.busy,      rem > 0);
        check_eq("busy_l2",   bus2.busy,      rem > 0);
        check_eq("coll_l1",   bus1.collision, e_coll);
        check_eq("coll_l2",   bus2.collision, e_coll);
        check_eq("err_l1",    bus1.addr_err,  e_err);
        check_eq("err_l2",    bus2.addr_err,  e_err);
        check_eq("out_a_l1",  bus1.out_a,     e1_out[0]);
        check_eq("vld_a_l1",  bus1.valid_a,   e1_vld[0]);
        check_eq("out_b_l1",  bus1.out_b,     e1_out[1]);
        check_eq("vld_b_l1",  bus1.valid_b,   e1_vld[1]);
        check_eq("out_a_l2",  bus2.out_a,     e2_out[0]);
        check_eq("vld_a_l2",  bus2.valid_a,   e2_vld[0]);
        check_eq("out_b_l2",  bus2.out_b,     e2_out[1]);
        check_eq("vld_b_l2",  bus2.valid_b,   e2_vld[1]);
`ifdef DPRAM_PARITY_EN
        check_eq("perr_a_l1", bus1.parity_err_a, e1_perr[0]);
        check_eq("perr_b_l1", bus1.parity_err_b, e1_perr[1]);
        check_eq("perr_a_l2", bus2.parity_err_a, e2_perr[0]);
        check_eq("perr_b_l2", bus2.parity_err_b, e2_perr[1]);
`endif
    endtask

    // Drive one cycle of stimulus (called at a negedge), advance the model, check after the edge.
    task automatic cycle(input string tag, input logic r,
                         input logic ca, input logic wa, input int aa, input int da,
                         input logic cb, input logic wb, input int ab, input int db);
        logic c [2], w [2];
        int   a [2], d [2];
        c[0] = ca; w[0] = wa; a[0] = aa; d[0] = da;
        c[1] = cb; w[1] = wb; a[1] = ab; d[1] = db;
        rst         = r;
        bus1.cs_a   = ca;  bus1.wr_a = wa;  bus1.addr_a = AW'(aa);  bus1.data_a = DW'(da);
        bus1.cs_b   = cb;  bus1.wr_b = wb;  bus1.addr_b = AW'(ab);  bus1.data_b = DW'(db);

        if (r) begin
            rem = MS;
            flip_addr = -1;
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
            e_coll = 1'b0;
            e_err  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                e1_out[p] = '0; e1_vld[p] = 1'b0; e1_perr[p] = 1'b0;
                e2_out[p] = '0; e2_vld[p] = 1'b0; e2_perr[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                e2_vld[p]  = e1_vld[p];
                e2_perr[p] = e1_vld[p] && e1_perr[p];
                if (e1_vld[p]) e2_out[p] = e1_out[p];
            end
            e_coll = 1'b0;
            e_err  = 1'b0;
            if (rem > 0) begin
                rem--;
                for (int p = 0; p < 2; p++) begin
                    e1_vld[p]  = 1'b0;
                    e1_perr[p] = 1'b0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    e1_vld[p]  = c[p] && !w[p];
                    e1_perr[p] = 1'b0;
                    if (c[p] && !w[p]) begin
                        if (a[p] < MS) begin
                            e1_out[p]  = mdl_mem[a[p]];
                            e1_perr[p] = (a[p] == flip_addr);
                        end else begin
                            e1_out[p] = '0;
                        end
                    end
                    if (c[p] && a[p] >= MS) e_err = 1'b1;
                end
                if (c[0] && w[0] && c[1] && w[1] && a[0] == a[1]) e_coll = 1'b1;
                for (int p = 1; p >= 0; p--) begin
                    if (c[p] && w[p] && a[p] < MS) begin
                        mdl_mem[a[p]] = DW'(d[p]);
                        if (a[p] == flip_addr) flip_addr = -1;
                    end
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (tag != "")
            $display("txn %-8s rst=%0b A(cs=%0b wr=%0b %03h %02h) B(cs=%0b wr=%0b %03h %02h) -> a=%02h/%0b b=%02h/%0b busy=%0b coll=%0b err=%0b",
                     tag, r, ca, wa, aa, da, cb, wb, ab, db, bus1.out_a, bus1.valid_a,
                     bus1.out_b, bus1.valid_b, bus1.busy, bus1.collision, bus1.addr_err);
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(MS, 1023));
        return int'($urandom_range(0, 31));
    endfunction

    task automatic rand_cycle(input logic r);
        cycle("", r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
              int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rand_addr(), int'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1'b1;
        bus1.cs_a = 1'b0; bus1.wr_a = 1'b0; bus1.addr_a = '0; bus1.data_a = '0;
        bus1.cs_b = 1'b0; bus1.wr_b = 1'b0; bus1.addr_b = '0; bus1.data_b = '0;
        @(negedge clk);
        cycle("reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Clear phase: random traffic must be ignored and busy must last exactly MS cycles.
        for (int i = 0; i < MS; i++) rand_cycle(1'b0);
        cycle("rd_zero",  0, 1, 0, 'h010, 0,    1, 0, 'h3E7, 0);
        cycle("wr_5a",    0, 1, 1, 'h010, 'h5A, 0, 0, 0,     0);
        cycle("rd_5a",    0, 0, 0, 0,     0,    1, 0, 'h010, 0);
        cycle("idle",     0, 0, 0, 0,     0,    0, 0, 0,     0);
        cycle("idle",     0, 0, 0, 0,     0,    0, 0, 0,     0);
        cycle("wr_11",    0, 1, 1, 'h020, 'h11, 0, 0, 0,     0);
        cycle("rdw_77",   0, 1, 1, 'h020, 'h77, 1, 0, 'h020, 0);
        cycle("rd_77",    0, 0, 0, 0,     0,    1, 0, 'h020, 0);
        cycle("coll",     0, 1, 1, 'h030, 'hAA, 1, 1, 'h030, 'hBB);
        cycle("rd_coll",  0, 1, 0, 'h030, 0,    1, 0, 'h030, 0);
        cycle("wr_3e7",   0, 1, 1, 'h3E7, 'h44, 0, 0, 0,     0);
        cycle("wr_oor",   0, 1, 1, 'h3E8, 'h33, 0, 0, 0,     0);
        cycle("rd_oor",   0, 1, 0, 'h3E8, 0,    1, 0, 'h3E7, 0);
        cycle("both_oor", 0, 1, 0, 'h3E9, 0,    1, 1, 'h3FF, 'h12);
        cycle("idle",     0, 0, 0, 0,     0,    0, 0, 0,     0);
`ifdef DPRAM_PARITY_EN
        cycle("wr_par",   0, 1, 1, 'h040, 'h5A, 0, 0, 0,     0);
        dut1.mem[64][DW] = ~dut1.mem[64][DW];
        dut2.mem[64][DW] = ~dut2.mem[64][DW];
        flip_addr = 64;
        cycle("rd_par",   0, 1, 0, 'h040, 0,    1, 0, 'h040, 0);
        cycle("idle",     0, 0, 0, 0,     0,    0, 0, 0,     0);
`endif
        // Sustained reads on both ports every cycle, then a fully random mix.
        for (int i = 0; i < 64; i++)
            cycle("", 0, 1, 0, int'($urandom_range(0, 31)), 0, 1, 0, int'($urandom_range(0, 31)), 0);
        for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 500; i++)
            cycle("", 0, 1, 0, int'($urandom_range(0, 31)), 0, 1, 0, int'($urandom_range(0, 31)), 0);
        cycle("rst_mid",  1, 1, 0, 'h010, 0,    1, 0, 'h020, 0);
        for (int i = 0; i < MS; i++) rand_cycle(1'b0);
        cycle("rd_clr",   0, 1, 0, 'h010, 0,    1, 0, 'h030, 0);
        for (int i = 0; i < 500; i++) rand_cycle(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
